// File: rtl/func_eval_seq.sv
// func_eval_seq: clocked N-input Boolean function held as a truth-table parameter.
// Evaluates single vectors through a valid/ready handshake (latency 1), or sweeps
// all 2^N_IN minterms and counts the ones.
// Optional feature macro: FUNC_EVAL_CHECK_EN -- when defined, err flags a sweep
// whose ones count differs from EXP_ONES; otherwise err is constant 0.
module func_eval_seq #(
  parameter int                      N_IN     = 4,
  parameter logic [(1<<N_IN)-1:0]    TRUTH    = 16'hFAD1,
  parameter int                      EXP_ONES = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_vec,
  output logic            out_valid,
  output logic            out_bit,
  input  logic            sweep_start,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   ones_cnt,
  output logic            err
);

  localparam int CW = N_IN + 1;

`ifdef FUNC_EVAL_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  // Folds the count check to a constant 0, leaving err tied low.
  localparam bit CHECK_EN = 1'b0;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [CW-1:0] acc_q, acc_d;
  logic [CW-1:0] ones_q, ones_d;
  logic          ov_q, ov_d;
  logic          ob_q, ob_d;
  logic          err_q, err_d;

  // Sweep request in IDLE takes priority over a presented vector.
  assign in_ready  = (state_q == S_IDLE) && !sweep_start;
  assign busy      = (state_q == S_SWEEP);
  assign done      = (state_q == S_DONE);
  assign out_valid = ov_q;
  assign out_bit   = ob_q;
  assign ones_cnt  = ones_q;
  assign err       = err_q;

  // Next-state: handshake evaluation in IDLE, minterm accumulation in SWEEP.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    ones_d  = ones_q;
    ov_d    = 1'b0;
    ob_d    = ob_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (sweep_start) begin
          state_d = S_SWEEP;
          idx_d   = '0;
          acc_d   = '0;
        end else if (in_valid) begin
          ov_d = 1'b1;
          ob_d = TRUTH[in_vec];
        end
      end
      S_SWEEP: begin
        acc_d = acc_q + CW'(TRUTH[idx_q]);
        idx_d = idx_q + N_IN'(1);
        if (idx_q == {N_IN{1'b1}}) begin
          // Final count is published on entry to DONE so it is stable while done=1.
          state_d = S_DONE;
          idx_d   = '0;
          ones_d  = acc_d;
          err_d   = CHECK_EN && (acc_d != CW'(EXP_ONES));
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; synchronous reset aborts any sweep and clears results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      ones_q  <= '0;
      ov_q    <= 1'b0;
      ob_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      ones_q  <= ones_d;
      ov_q    <= ov_d;
      ob_q    <= ob_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_func_eval_seq.sv
// Self-checking bench for func_eval_seq: default 4-input function, a 3-input
// constant-one variant, and an instance expecting 9 ones (err path when the
// FUNC_EVAL_CHECK_EN macro is defined).
module tb_func_eval_seq;

`ifdef FUNC_EVAL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, sweep_start, swb, swc;
  logic [3:0] in_vec;

  logic a_rdy, a_ov, a_ob, a_busy, a_done, a_err;
  logic [4:0] a_ones;
  logic b_rdy, b_ov, b_ob, b_busy, b_done, b_err;
  logic [3:0] b_ones;
  logic c_rdy, c_ov, c_ob, c_busy, c_done, c_err;
  logic [4:0] c_ones;

  func_eval_seq u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_rdy), .in_vec(in_vec),
    .out_valid(a_ov), .out_bit(a_ob), .sweep_start(sweep_start), .busy(a_busy),
    .done(a_done), .ones_cnt(a_ones), .err(a_err));

  func_eval_seq #(.N_IN(3), .TRUTH(8'hFF)) u_b (
    .clk(clk), .rst(rst), .in_valid(1'b0), .in_ready(b_rdy), .in_vec(in_vec[2:0]),
    .out_valid(b_ov), .out_bit(b_ob), .sweep_start(swb), .busy(b_busy),
    .done(b_done), .ones_cnt(b_ones), .err(b_err));

  func_eval_seq #(.EXP_ONES(9)) u_c (
    .clk(clk), .rst(rst), .in_valid(1'b0), .in_ready(c_rdy), .in_vec(in_vec),
    .out_valid(c_ov), .out_bit(c_ob), .sweep_start(swc), .busy(c_busy),
    .done(c_done), .ones_cnt(c_ones), .err(c_err));

  int n_chk = 0;
  int n_fail = 0;

  // Reference function written from its sum-of-products form.
  function automatic bit f_ref(input logic [3:0] v);
    bit a, b, c, d;
    {a, b, c, d} = v;
    return (a & d) | (~a & b & c) | (b & ~d) | (~a & ~c & ~d);
  endfunction

  function automatic int ref_ones();
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(f_ref(4'(i)));
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits out a sweep on instance 0/1/2, counting busy cycles (bounded).
  task automatic wait_sweep(input int which, output int cyc);
    logic bz;
    cyc = 0;
    forever begin
      case (which)
        0: bz = a_busy;
        1: bz = b_busy;
        default: bz = c_busy;
      endcase
      if (!bz || cyc >= 100) break;
      if (which == 0) chk("a_no_out_in_sweep", {31'd0, a_ov}, 32'd0);
      cyc++;
      tick();
    end
  endtask

  int cyc;
  int exp10;
  logic exp_ov, exp_ob;

  initial begin
    rst = 1'b1; in_valid = 1'b0; sweep_start = 1'b0; swb = 1'b0; swc = 1'b0; in_vec = '0;
    exp10 = ref_ones();

    // Reset while idle
    tick(); tick();
    chk("rst_ov",   {31'd0, a_ov},   32'd0);
    chk("rst_ob",   {31'd0, a_ob},   32'd0);
    chk("rst_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_done", {31'd0, a_done}, 32'd0);
    chk("rst_ones", {27'd0, a_ones}, 32'd0);
    chk("rst_err",  {31'd0, a_err},  32'd0);
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", {31'd0, a_rdy}, 32'd1);

    // Directed back-to-back singles
    in_valid = 1'b1; in_vec = 4'b0000; tick();
    chk("s0_ov", {31'd0, a_ov}, 32'd1); chk("s0_ob", {31'd0, a_ob}, 32'd1);
    in_vec = 4'b0101; tick();
    chk("s1_ov", {31'd0, a_ov}, 32'd1); chk("s1_ob", {31'd0, a_ob}, 32'd0);
    in_vec = 4'b1001; tick();
    chk("s2_ov", {31'd0, a_ov}, 32'd1); chk("s2_ob", {31'd0, a_ob}, 32'd1);
    in_valid = 1'b0; in_vec = 4'bxxxx; tick();
    chk("s_ov_drop", {31'd0, a_ov}, 32'd0); chk("s_ob_hold", {31'd0, a_ob}, 32'd1);

    // Random singles against the reference function
    exp_ob = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_vec = 4'($urandom);
      #1;
      chk("r_rdy", {31'd0, a_rdy}, 32'd1);
      exp_ov = in_valid;
      if (in_valid) exp_ob = f_ref(in_vec);
      tick();
      chk("r_ov", {31'd0, a_ov}, {31'd0, exp_ov});
      chk("r_ob", {31'd0, a_ob}, {31'd0, exp_ob});
    end
    in_valid = 1'b0;
    tick();

    // Default sweep
    sweep_start = 1'b1; tick(); sweep_start = 1'b0;
    chk("sw_rdy_busy", {31'd0, a_rdy}, 32'd0);
    wait_sweep(0, cyc);
    chk("sw_cycles", cyc, 32'd16);
    chk("sw_done",   {31'd0, a_done}, 32'd1);
    chk("sw_rdy_done", {31'd0, a_rdy}, 32'd0);
    chk("sw_ones",   {27'd0, a_ones}, exp10);
    chk("sw_err",    {31'd0, a_err},  {31'd0, CHK && (exp10 != 10)});
    tick();
    chk("sw_done_pulse", {31'd0, a_done}, 32'd0);
    chk("sw_ones_hold",  {27'd0, a_ones}, exp10);
    chk("sw_rdy_idle",   {31'd0, a_rdy}, 32'd1);

    // Conflict: sweep_start beats in_valid
    sweep_start = 1'b1; in_valid = 1'b1; in_vec = 4'b0000;
    #1;
    chk("cf_rdy", {31'd0, a_rdy}, 32'd0);
    tick(); sweep_start = 1'b0; in_valid = 1'b0;
    chk("cf_no_ov", {31'd0, a_ov}, 32'd0);
    chk("cf_busy",  {31'd0, a_busy}, 32'd1);
    wait_sweep(0, cyc);
    chk("cf_cycles", cyc, 32'd16);
    chk("cf_ones", {27'd0, a_ones}, exp10);
    tick();

    // Reset mid-sweep at sweep cycle 7
    sweep_start = 1'b1; tick(); sweep_start = 1'b0;
    repeat (6) tick();
    chk("mr_busy_pre", {31'd0, a_busy}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mr_busy", {31'd0, a_busy}, 32'd0);
    chk("mr_done", {31'd0, a_done}, 32'd0);
    chk("mr_ones", {27'd0, a_ones}, 32'd0);
    repeat (20) begin
      tick();
      chk("mr_no_done", {31'd0, a_done}, 32'd0);
    end

    // New sweep with random noise on the request lines while busy
    sweep_start = 1'b1; tick(); sweep_start = 1'b0;
    cyc = 0;
    while (a_busy && cyc < 100) begin
      chk("nz_no_ov", {31'd0, a_ov}, 32'd0);
      sweep_start = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      in_vec = 4'($urandom);
      cyc++;
      tick();
    end
    sweep_start = 1'b0; in_valid = 1'b0;
    chk("nz_cycles", cyc, 32'd16);
    chk("nz_done", {31'd0, a_done}, 32'd1);
    chk("nz_ones", {27'd0, a_ones}, exp10);
    tick();
    chk("nz_no_ov_done", {31'd0, a_ov}, 32'd0);

    // 3-input constant-one variant: full count without wrap
    swb = 1'b1; tick(); swb = 1'b0;
    wait_sweep(1, cyc);
    chk("b_cycles", cyc, 32'd8);
    chk("b_done", {31'd0, b_done}, 32'd1);
    chk("b_ones", {28'd0, b_ones}, 32'd8);
    chk("b_err",  {31'd0, b_err},  {31'd0, CHK});
    tick();

    // Expected-count mismatch instance
    swc = 1'b1; tick(); swc = 1'b0;
    wait_sweep(2, cyc);
    chk("c_cycles", cyc, 32'd16);
    chk("c_ones", {27'd0, c_ones}, exp10);
    chk("c_err",  {31'd0, c_err},  {31'd0, CHK && (exp10 != 9)});
    tick();
    chk("c_err_hold", {31'd0, c_err}, {31'd0, CHK && (exp10 != 9)});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
